uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Store-mapped UART transmitter: byte stores to TX_ADDR are queued in a small FIFO
// and sent 8N1. Defining UART_TX_PARITY_EN adds an even-parity bit (8E1).
module uart_tx_fifo #(
    parameter int          DEPTH        = 16,
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [31:0] TX_ADDR      = 32'hFFFFFFFC
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic [31:0] wData,
    input  logic [31:0] addr,
    input  logic        wEn,
    output logic        uartFifoFull,
    output logic        tx
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic [7:0] mem [DEPTH];
    logic       push;
    logic       pop;
    logic       baud_end;
    logic       fifo_nonempty;
    logic [7:0] head;
    logic       unused_wdata;

    assign unused_wdata  = ^wData[31:8];
    assign uartFifoFull  = (count_q == CNT_W'(DEPTH));
    assign fifo_nonempty = (count_q != '0);
    assign baud_end      = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign head          = mem[rd_ptr_q];
    assign tx            = tx_q;

    // Fullness comes from the registered count, so a full FIFO drops a store
    // even on the edge where the transmitter frees a slot.
    assign push = wEn && (addr == TX_ADDR) && !uartFifoFull;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wData[7:0];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // tx_d is the line level for the cycle after the edge, which keeps tx a pure flop.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_end ? '0 : baud_q + BAUD_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    state_d = START;
                    shift_d = head;
                    tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^head;
`endif
                end
            end
            START: begin
                if (baud_end) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (baud_end) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_end) begin
                    if (fifo_nonempty) begin
                        // Back-to-back frames: next start bit follows the stop bit directly.
                        pop     = 1'b1;
                        state_d = START;
                        shift_d = head;
                        tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^head;
`endif
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (state_d != state_q) begin
            baud_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue/frame-position model checked every cycle, a serial
// receiver, and literal frame patterns. Honours UART_TX_PARITY_EN if defined.
module tb_uart_tx_fifo;

    localparam int          DEPTH = 4;
    localparam int          CPB   = 4;
    localparam logic [31:0] TXA   = 32'hFFFFFFFC;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [10:0] F_A5 = {1'b1, 1'b0, 8'hA5, 1'b0};
    localparam logic [10:0] F_3C = {1'b1, 1'b0, 8'h3C, 1'b0};
    localparam logic [10:0] F_07 = {1'b1, 1'b1, 8'h07, 1'b0};
    localparam logic [10:0] F_03 = {1'b1, 1'b0, 8'h03, 1'b0};
`else
    localparam int NB = 10;
    localparam logic [10:0] F_A5 = {1'b0, 1'b1, 8'hA5, 1'b0};
    localparam logic [10:0] F_3C = {1'b0, 1'b1, 8'h3C, 1'b0};
    localparam logic [10:0] F_07 = {1'b0, 1'b1, 8'h07, 1'b0};
    localparam logic [10:0] F_03 = {1'b0, 1'b1, 8'h03, 1'b0};
`endif
    localparam int FRAME = NB * CPB;

    logic        clk = 1'b0;
    logic        rstN;
    logic [31:0] wData;
    logic [31:0] addr;
    logic        wEn;
    logic        uartFifoFull;
    logic        tx;

    int total = 0;
    int bad   = 0;

    uart_tx_fifo #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .TX_ADDR(TXA)) dut (
        .clk(clk), .rstN(rstN), .wData(wData), .addr(addr), .wEn(wEn),
        .uartFifoFull(uartFifoFull), .tx(tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: queue of accepted bytes plus the position inside the frame on the wire.
    logic [7:0] mq[$];
    bit         m_busy = 1'b0;
    int         m_pos  = 0;
    logic [7:0] m_cur  = 8'h00;

    function automatic logic exp_bit(input logic [7:0] b, input int pos);
        int idx;
        idx = pos / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mq.delete();
            m_busy = 1'b0;
            m_pos  = 0;
        end else begin
            int  n;
            bit  acc;
            n   = mq.size();
            acc = wEn && (addr == TXA) && (n != DEPTH);
            if (m_busy) begin
                if (m_pos == FRAME - 1) begin
                    if (n > 0) begin
                        m_cur = mq.pop_front();
                        m_pos = 0;
                    end else begin
                        m_busy = 1'b0;
                    end
                end else begin
                    m_pos++;
                end
            end else if (n > 0) begin
                m_cur  = mq.pop_front();
                m_busy = 1'b1;
                m_pos  = 0;
            end
            if (acc) mq.push_back(wData[7:0]);
        end
    end

    always @(negedge clk) begin
        chk("tx_vs_model", tx, m_busy ? exp_bit(m_cur, m_pos) : 1'b1);
        chk("full_vs_model", uartFifoFull, (mq.size() == DEPTH));
        chk("count_vs_model", 32'(dut.count_q), mq.size());
    end

    // Serial receiver: samples the middle of each bit of the DUT line.
    int         rx_cnt = -1;
    int         rx_idx;
    logic [7:0] rx_sh = 8'h00;
    logic [7:0] rx_q[$];

    always @(negedge clk) begin
        if (!rstN) rx_cnt = -1;
        else if (rx_cnt < 0) begin
            if (tx === 1'b0) rx_cnt = 0;
        end else rx_cnt++;
        if (rx_cnt >= 0 && (rx_cnt % CPB) == 2) begin
            rx_idx = rx_cnt / CPB;
            if (rx_idx >= 1 && rx_idx <= 8) rx_sh[rx_idx-1] = tx;
            if (rx_idx == NB - 1) begin
                rx_q.push_back(rx_sh);
                rx_cnt = -1;
            end
        end
    end

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wData = d;
        wEn   = 1'b1;
        @(posedge clk);
        #1;
        wEn   = 1'b0;
        addr  = 32'h0;
        wData = 32'h0;
    endtask

    task automatic wait_start(input string name, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (tx !== 1'b0 && lat < 20);
        chk(name, tx, 1'b0);
    endtask

    task automatic check_frame(input logic [10:0] bits, input string name);
        int err;
        err = 0;
        for (int c = 0; c < FRAME; c++) begin
            if (tx !== bits[c / CPB]) err++;
            @(negedge clk);
        end
        chk(name, err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        wEn   = 1'b0;
        addr  = 32'h0;
        wData = 32'h0;
        rstN  = 1'b1;
        #2 rstN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", tx, 1'b1);
        chk("reset_full", uartFifoFull, 1'b0);
        chk("reset_count", 32'(dut.count_q), 0);
        rstN = 1'b1;

        // Single byte, stored on the first edge after reset release.
        do_store(TXA, 32'h000000A5);
        chk("a5_count_after_push", 32'(dut.count_q), 1);
        wait_start("a5_start", lat);
        chk("a5_latency", lat, 2);
        check_frame(F_A5, "a5_frame");
        chk("a5_rx_n", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("a5_rx_byte", rx_q.pop_front(), 8'hA5);

        // Stores to other addresses are ignored.
        @(posedge clk); #1;
        do_store(32'hFFFFFFF8, 32'h41);
        do_store(32'h00000010, 32'h42);
        repeat (3) @(posedge clk);
        #1;
        chk("badaddr_count", 32'(dut.count_q), 0);
        chk("badaddr_tx", tx, 1'b1);

        // Burst of five, then one more store while full.
        rx_q.delete();
        for (int i = 1; i <= 5; i++) do_store(TXA, i);
        chk("burst_full", uartFifoFull, 1'b1);
        do_store(TXA, 32'h66);
        chk("burst_drop_count", 32'(dut.count_q), DEPTH);
        repeat (5 * FRAME + 10) @(negedge clk);
        chk("burst_rx_n", rx_q.size(), 5);
        for (int i = 1; i <= 5; i++)
            if (rx_q.size() > 0) chk("burst_rx_byte", rx_q.pop_front(), i);

        // Store while full on the very edge that pops.
        @(posedge clk); #1;
        rx_q.delete();
        do_store(TXA, 32'h11);
        do_store(TXA, 32'h22);
        do_store(TXA, 32'h33);
        do_store(TXA, 32'h44);
        do_store(TXA, 32'h55);
        repeat (FRAME - 4) @(posedge clk);
        #1;
        chk("popedge_full_before", uartFifoFull, 1'b1);
        do_store(TXA, 32'hEE);
        chk("popedge_count_after", 32'(dut.count_q), DEPTH - 1);
        chk("popedge_full_after", uartFifoFull, 1'b0);
        repeat (5 * FRAME + 10) @(negedge clk);
        chk("popedge_rx_n", rx_q.size(), 5);
        for (int i = 1; i <= 5; i++)
            if (rx_q.size() > 0) chk("popedge_rx_byte", rx_q.pop_front(), 8'h11 * i);

        // Reset in the middle of data bit 3 with two bytes queued.
        @(posedge clk); #1;
        do_store(TXA, 32'h00);
        do_store(TXA, 32'h5A);
        do_store(TXA, 32'hC3);
        repeat (15) @(posedge clk);
        #2;
        chk("midframe_tx_low", tx, 1'b0);
        chk("midframe_count", 32'(dut.count_q), 2);
        rstN = 1'b0;
        #1;
        chk("async_rst_tx", tx, 1'b1);
        chk("async_rst_full", uartFifoFull, 1'b0);
        chk("async_rst_count", 32'(dut.count_q), 0);
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        rx_q.delete();
        chk("post_rst_tx", tx, 1'b1);
        do_store(TXA, 32'h3C);
        chk("post_rst_push", 32'(dut.count_q), 1);
        wait_start("3c_start", lat);
        chk("3c_latency", lat, 2);
        check_frame(F_3C, "3c_frame");
        chk("3c_rx_n", rx_q.size(), 1);

        // Parity-sensitive bytes (8N1 frames when parity is not built in).
        @(posedge clk); #1;
        do_store(TXA, 32'h07);
        wait_start("07_start", lat);
        check_frame(F_07, "07_frame");
        @(posedge clk); #1;
        do_store(TXA, 32'h03);
        wait_start("03_start", lat);
        check_frame(F_03, "03_frame");
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
